inst_fetch_queue: RTL and testbench
===================================

// Module: inst_fetch_queue
// PURPOSE
//   Parametrised instruction queue between fetch (PC/instruction RAM) and decode.
//   Accepts up to FETCH_WIDTH {pc, inst} pairs per cycle and supplies one in order per cycle to ID.
//   Decouples RAM read latency from ID back-pressure; branch redirects from ID flush it in one cycle.
//   Replaces the single-entry IF/ID register and PC-delay register.
// PARAMETERS
//   DEPTH        8   entries; power of 2, >= 2*FETCH_WIDTH
//   FETCH_WIDTH  2   push lanes per cycle, 1..4
//   ADDR_W       32  PC width
//   INST_W       32  instruction width
// PORTS
//   clk           in   1                    clock, rising edge
//   rst           in   1                    reset, asynchronous, active-low
//   flush_i       in   1                    branch redirect; discard all entries
//   push_valid_i  in   FETCH_WIDTH          per-lane valid; lane 0 is oldest
//   push_pc_i     in   FETCH_WIDTH*ADDR_W   lane k at [k*ADDR_W +: ADDR_W]
//   push_inst_i   in   FETCH_WIDTH*INST_W   lane k at [k*INST_W +: INST_W]
//   push_ready_o  out  1                    free slots >= FETCH_WIDTH
//   pop_ready_i   in   1                    ID accepts the head entry this cycle
//   pop_valid_o   out  1                    head entry valid
//   pop_pc_o      out  ADDR_W               head PC; 0 when pop_valid_o=0
//   pop_inst_o    out  INST_W               head instruction; 0 when pop_valid_o=0
//   count_o       out  $clog2(DEPTH+1)      occupied entries
// BEHAVIOUR
//   Reset (rst=0, async): wr_ptr=rd_ptr=0, count=0.
//     Outputs: pop_valid_o=0, pop_pc_o=0, pop_inst_o=0, count_o=0, push_ready_o=1.
//     Storage array is not cleared; it is masked by pop_valid_o.
//   State: wr_ptr, rd_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH); count register.
//   push_ready_o = (DEPTH - count) >= FETCH_WIDTH, from registered count only.
//     No look-ahead on a same-cycle pop.
//   Push accepted iff push_ready_o=1. n_push = number of contiguous valid lanes from lane 0.
//     Lanes after the first invalid lane are ignored (protocol error, not stored).
//     Lane k writes storage[(wr_ptr+k) mod DEPTH]; wr_ptr += n_push.
//     If push_ready_o=0, all lanes are dropped. The fetch side must hold the PC and retry.
//   Pop fires iff pop_valid_o & pop_ready_i; rd_ptr += 1.
//     pop_valid_o = (count != 0).
//     pop_pc_o/pop_inst_o are combinational reads of storage[rd_ptr], ANDed with pop_valid_o.
//   Latency: a pushed entry is visible at the head no earlier than the cycle after the push.
//     No same-cycle bypass.
//   Simultaneous push and pop: count_next = count + n_push - pop. Both are legal in the same cycle.
//   Flush has the highest priority. In the flush cycle, push and pop are both ignored.
//     Next cycle: wr_ptr=rd_ptr=count=0 and pop_valid_o=0.
//     The pop handshake in the flush cycle does not count as consumed.
//   Full (count=DEPTH): pop_valid_o=1, push_ready_o=0.
//   Empty: pop_valid_o=0 and pop_ready_i is ignored; count never underflows.
//   Ordering: FIFO across cycles; within one cycle, lane 0 precedes lane 1, and so on.
//   Reset asserted mid-operation clears all state immediately, regardless of clk.
// TESTING
//   1. Reset: rst=0, then release.
//      -> pop_valid_o=0, count_o=0, push_ready_o=1, pop_pc_o=0, pop_inst_o=0.
//   2. Single lane: push pc=0x1c000000, inst=0x02800421 with pop_ready_i=0.
//      -> next cycle count_o=1, pop_valid_o=1, head shows those values.
//      -> pop: count_o=0 next cycle.
//   3. Two lanes, wrap: pre-fill to wr_ptr=7, pop_ready_i=1, push pcs 0x100 and 0x104.
//      -> entries stored at slots 7 and 0; popped in order 0x100, 0x104.
//   4. Full/back-pressure: DEPTH=8, FETCH_WIDTH=2, pop_ready_i=0, push 2/cycle.
//      -> push_ready_o drops when count_o=7 or 8.
//      -> pushes while ready=0 are not stored; pop, push, pop sequence keeps order.
//   5. Non-contiguous lanes: push_valid_i=2'b10 -> nothing stored, count_o unchanged.
//   6. Flush: count_o=5, same cycle push 2 + pop + flush_i=1.
//      -> next cycle count_o=0, pop_valid_o=0; the following push appears at head.
//   7. Reset mid-stream: rst=0 for half a cycle at count_o=4.
//      -> count_o=0 and pop_valid_o=0 immediately.
//   8. Random: push/pop/flush vs scoreboard, 10k cycles.
//      -> no loss, duplication or reordering; count_o matches the model.

Source files
------------

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_queue
// Purpose  : Multi-lane-push, single-pop in-order instruction queue that sits
//            between fetch and decode; flushed in one cycle on redirect.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_queue #(
   parameter int DEPTH       = 8,
   parameter int FETCH_WIDTH = 2,
   parameter int ADDR_W      = 32,
   parameter int INST_W      = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush_i,
   input  logic [FETCH_WIDTH-1:0]        push_valid_i,
   input  logic [FETCH_WIDTH*ADDR_W-1:0] push_pc_i,
   input  logic [FETCH_WIDTH*INST_W-1:0] push_inst_i,
   output logic                          push_ready_o,
   input  logic                          pop_ready_i,
   output logic                          pop_valid_o,
   output logic [ADDR_W-1:0]             pop_pc_o,
   output logic [INST_W-1:0]             pop_inst_o,
   output logic [$clog2(DEPTH+1)-1:0]    count_o
);

   localparam int C_PTR_W = $clog2(DEPTH);
   localparam int C_CNT_W = $clog2(DEPTH+1);
   localparam int C_NP_W  = $clog2(FETCH_WIDTH+1);
   localparam logic [C_CNT_W-1:0] C_READY_MAX = C_CNT_W'(DEPTH - FETCH_WIDTH);

   logic [ADDR_W-1:0]      pc_mem_q   [DEPTH];
   logic [INST_W-1:0]      inst_mem_q [DEPTH];

   logic [C_PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [C_PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [C_CNT_W-1:0]     count_q,  count_d;

   logic [FETCH_WIDTH-1:0] w_lane_we;
   logic [C_NP_W-1:0]      w_n_push;
   logic                   w_pop_fire;

   // Readiness looks only at the registered count, never at a same-cycle pop.
   assign push_ready_o = (count_q <= C_READY_MAX);
   assign pop_valid_o  = (count_q != '0);
   assign count_o      = count_q;
   assign pop_pc_o     = pc_mem_q[rd_ptr_q]   & {ADDR_W{pop_valid_o}};
   assign pop_inst_o   = inst_mem_q[rd_ptr_q] & {INST_W{pop_valid_o}};
   assign w_pop_fire   = pop_valid_o & pop_ready_i & ~flush_i;

   // Only the contiguous run of valid lanes starting at lane 0 is accepted.
   always_comb begin
      w_lane_we = '0;
      w_n_push  = '0;
      if (push_ready_o && !flush_i) begin
         w_lane_we[0] = push_valid_i[0];
         for (int k = 1; k < FETCH_WIDTH; k++) begin
            w_lane_we[k] = w_lane_we[k-1] & push_valid_i[k];
         end
      end
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         w_n_push = w_n_push + C_NP_W'(w_lane_we[k]);
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + C_PTR_W'(w_n_push);
      rd_ptr_d = rd_ptr_q + C_PTR_W'(w_pop_fire);
      count_d  = count_q + C_CNT_W'(w_n_push) - C_CNT_W'(w_pop_fire);
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is left uninitialised; pop_valid_o masks stale contents.
   always_ff @(posedge clk) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         if (w_lane_we[k]) begin
            pc_mem_q[wr_ptr_q + C_PTR_W'(k)]   <= push_pc_i[k*ADDR_W +: ADDR_W];
            inst_mem_q[wr_ptr_q + C_PTR_W'(k)] <= push_inst_i[k*INST_W +: INST_W];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_queue
// Purpose  : Self-checking bench for inst_fetch_queue against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;

   localparam int DEPTH = 8;
   localparam int FW    = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic [FW-1:0] push_valid;
   logic [FW*32-1:0] push_pc;
   logic [FW*32-1:0] push_inst;
   logic          push_ready;
   logic          pop_ready;
   logic          pop_valid;
   logic [31:0]   pop_pc;
   logic [31:0]   pop_inst;
   logic [3:0]    count;

   int total = 0;
   int bad   = 0;

   logic [63:0] q[$];

   always #5 clk = ~clk;

   inst_fetch_queue #(
      .DEPTH(DEPTH), .FETCH_WIDTH(FW), .ADDR_W(32), .INST_W(32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (flush),
      .push_valid_i (push_valid),
      .push_pc_i    (push_pc),
      .push_inst_i  (push_inst),
      .push_ready_o (push_ready),
      .pop_ready_i  (pop_ready),
      .pop_valid_o  (pop_valid),
      .pop_pc_o     (pop_pc),
      .pop_inst_o   (pop_inst),
      .count_o      (count)
   );

   // Queue-level model: flush wins, push gated by pre-cycle free space.
   task automatic model_step();
      bit rdy;
      if (flush) begin
         q.delete();
      end else begin
         rdy = (DEPTH - q.size()) >= FW;
         if (pop_ready && q.size() != 0) void'(q.pop_front());
         if (rdy) begin
            for (int k = 0; k < FW; k++) begin
               if (!push_valid[k]) break;
               q.push_back({push_pc[k*32 +: 32], push_inst[k*32 +: 32]});
            end
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int k, input logic [31:0] pc, input logic [31:0] inst);
      push_pc[k*32 +: 32]   = pc;
      push_inst[k*32 +: 32] = inst;
   endtask

   task automatic idle();
      flush      = 1'b0;
      push_valid = '0;
      pop_ready  = 1'b0;
   endtask

   task automatic do_flush();
      idle();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic push_n(input int n, input logic [31:0] base);
      push_valid = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
      set_lane(0, base,     ~base);
      set_lane(1, base + 4, ~(base + 4));
      tick();
      push_valid = '0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle();
      push_pc = '0;
      push_inst = '0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (pop_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", pop_valid); end
      total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
      total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", push_ready); end
      total++; if (pop_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", pop_pc); end
      total++; if (pop_inst !== 32'h0) begin bad++; $display("FAIL reset_inst: got %h want 0", pop_inst); end
      rst = 1'b1;
      q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      idle();
      push_valid = 2'b01;
      set_lane(0, 32'h1c000000, 32'h02800421);
      set_lane(1, 32'hffff0000, 32'hffff0001);
      tick();
      push_valid = '0;
      total++; if (count !== 4'd1) begin bad++; $display("FAIL single_count: got %0d want 1", count); end
      total++; if (pop_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", pop_valid); end
      total++; if (pop_pc !== 32'h1c000000) begin bad++; $display("FAIL single_pc: got %h want 1c000000", pop_pc); end
      total++; if (pop_inst !== 32'h02800421) begin bad++; $display("FAIL single_inst: got %h want 02800421", pop_inst); end
      pop_ready = 1'b1;
      tick();
      pop_ready = 1'b0;
      total++; if (count !== 4'd0) begin bad++; $display("FAIL single_pop_count: got %0d want 0", count); end
      total++; if (pop_pc !== 32'h0) begin bad++; $display("FAIL single_pop_pc: got %h want 0", pop_pc); end
   endtask

   task automatic test_wrap();
      do_flush();
      pop_ready = 1'b1;
      for (int i = 0; i < 7; i++) push_n(1, 32'h1000 + 32'(i) * 8);
      total++; if (count !== 4'd1) begin bad++; $display("FAIL wrap_prefill: got %0d want 1", count); end
      push_n(2, 32'h100);
      pop_ready = 1'b0;
      total++; if (pop_pc !== 32'h100) begin bad++; $display("FAIL wrap_head0: got %h want 100", pop_pc); end
      total++; if (pop_inst !== ~32'h100) begin bad++; $display("FAIL wrap_inst0: got %h want %h", pop_inst, ~32'h100); end
      pop_ready = 1'b1;
      tick();
      total++; if (pop_pc !== 32'h104) begin bad++; $display("FAIL wrap_head1: got %h want 104", pop_pc); end
      tick();
      pop_ready = 1'b0;
      total++; if (pop_valid !== 1'b0) begin bad++; $display("FAIL wrap_empty: got %b want 0", pop_valid); end
   endtask

   task automatic test_full();
      do_flush();
      push_n(2, 32'h3000); push_n(2, 32'h3008); push_n(2, 32'h3010); push_n(1, 32'h3018);
      total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL full_ready_at7: got %b want 0", push_ready); end
      push_n(2, 32'hdead0000);
      total++; if (count !== 4'd7) begin bad++; $display("FAIL full_drop_at7: got %0d want 7", count); end
      do_flush();
      for (int i = 0; i < 4; i++) begin
         total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL full_ready_pre%0d: got %b want 1", i, push_ready); end
         push_n(2, 32'h4000 + 32'(i) * 8);
      end
      total++; if (count !== 4'd8) begin bad++; $display("FAIL full_count: got %0d want 8", count); end
      total++; if (push_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", push_ready); end
      total++; if (pop_valid !== 1'b1) begin bad++; $display("FAIL full_valid: got %b want 1", pop_valid); end
      push_n(2, 32'hbad00000);
      total++; if (count !== 4'd8) begin bad++; $display("FAIL full_drop: got %0d want 8", count); end
      pop_ready = 1'b1;
      push_n(2, 32'hbad10000);
      pop_ready = 1'b0;
      total++; if (count !== 4'd7) begin bad++; $display("FAIL full_pop_push: got %0d want 7", count); end
      push_n(2, 32'h5000);
      pop_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         total++;
         if (pop_pc !== ((q.size() != 0) ? q[0][63:32] : 32'h0)) begin
            bad++; $display("FAIL full_drain%0d: got %h want %h", i, pop_pc, (q.size() != 0) ? q[0][63:32] : 32'h0);
         end
         tick();
      end
      pop_ready = 1'b0;
      total++; if (count !== 4'd0) begin bad++; $display("FAIL full_drained: got %0d want 0", count); end
   endtask

   task automatic test_noncontig();
      do_flush();
      push_n(1, 32'h6000);
      push_valid = 2'b10;
      set_lane(0, 32'h7000, 32'h7001);
      set_lane(1, 32'h7004, 32'h7005);
      tick();
      push_valid = '0;
      total++; if (count !== 4'd1) begin bad++; $display("FAIL noncontig_count: got %0d want 1", count); end
      pop_ready = 1'b1;
      tick();
      pop_ready = 1'b0;
      total++; if (pop_valid !== 1'b0) begin bad++; $display("FAIL noncontig_stored: got %b want 0", pop_valid); end
   endtask

   task automatic test_flush();
      do_flush();
      push_n(2, 32'h8000); push_n(2, 32'h8008); push_n(1, 32'h8010);
      total++; if (count !== 4'd5) begin bad++; $display("FAIL flush_pre: got %0d want 5", count); end
      flush = 1'b1;
      pop_ready = 1'b1;
      push_n(2, 32'h9000);
      flush = 1'b0;
      pop_ready = 1'b0;
      total++; if (count !== 4'd0) begin bad++; $display("FAIL flush_count: got %0d want 0", count); end
      total++; if (pop_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", pop_valid); end
      push_n(1, 32'h2000);
      total++; if (pop_pc !== 32'h2000) begin bad++; $display("FAIL flush_next_head: got %h want 2000", pop_pc); end
      total++; if (count !== 4'd1) begin bad++; $display("FAIL flush_next_count: got %0d want 1", count); end
   endtask

   task automatic test_reset_mid();
      do_flush();
      push_n(2, 32'ha000); push_n(2, 32'ha008);
      total++; if (count !== 4'd4) begin bad++; $display("FAIL rstmid_pre: got %0d want 4", count); end
      #2;
      rst = 1'b0;
      #1;
      total++; if (count !== 4'd0) begin bad++; $display("FAIL rstmid_count: got %0d want 0", count); end
      total++; if (pop_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", pop_valid); end
      #1;
      rst = 1'b1;
      q.delete();
      @(posedge clk);
      #1;
      total++; if (push_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b want 1", push_ready); end
   endtask

   task automatic test_random();
      logic [31:0] exp_pc, exp_inst;
      do_flush();
      for (int c = 0; c < 10000; c++) begin
         flush      = ($urandom_range(0, 49) == 0);
         pop_ready  = ($urandom_range(0, 9) < 6);
         push_valid = FW'($urandom_range(0, 3));
         set_lane(0, $urandom, $urandom);
         set_lane(1, $urandom, $urandom);
         exp_pc   = (q.size() != 0) ? q[0][63:32] : 32'h0;
         exp_inst = (q.size() != 0) ? q[0][31:0]  : 32'h0;
         total++; if (int'(count) != q.size()) begin bad++; $display("FAIL rand_count@%0d: got %0d want %0d", c, count, q.size()); end
         total++; if (pop_valid !== (q.size() != 0)) begin bad++; $display("FAIL rand_valid@%0d: got %b want %b", c, pop_valid, q.size() != 0); end
         total++; if (push_ready !== ((DEPTH - q.size()) >= FW)) begin bad++; $display("FAIL rand_ready@%0d: got %b want %b", c, push_ready, (DEPTH - q.size()) >= FW); end
         total++; if (pop_pc !== exp_pc) begin bad++; $display("FAIL rand_pc@%0d: got %h want %h", c, pop_pc, exp_pc); end
         total++; if (pop_inst !== exp_inst) begin bad++; $display("FAIL rand_inst@%0d: got %h want %h", c, pop_inst, exp_inst); end
         tick();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_full();
      test_noncontig();
      test_flush();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
